imem_port_arbiter: RTL and testbench

//  Shares the single-port instruction memory between the IF stage (fetch) and a program loader (read/write).

---
 rtl/imem_port_arbiter.sv | 146 ++++++++++++++
 tb/tb_imem_port_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter: shares a single-port instruction memory between the
// IF stage (fetch, read-only) and a program loader (read/write).
//
// Optional feature: define IMEM_ARB_STATS_EN to add saturating grant
// counters stat_if_cnt / stat_ld_cnt.
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-low reset
//   if_req/if_addr  fetch request; if_gnt same-cycle accept
//   if_rvalid/if_rdata  fetch read return (1 cycle after if_gnt)
//   ld_req/ld_we/ld_addr/ld_wdata/ld_lock  loader request and lock mode
//   ld_gnt, ld_rvalid/ld_rdata, ld_err  loader accept, read return, OOR write pulse
//   cpu_hold        stall IF/PC this cycle
//   mem_addr/mem_we/mem_wdata/mem_rdata  memory side (1-cycle read latency)
module imem_port_arbiter #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DEPTH       = 46,
  parameter int unsigned LD_MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_wdata,
  input  logic              ld_lock,
  output logic              ld_gnt,
  output logic              ld_rvalid,
  output logic [31:0]       ld_rdata,
  output logic              ld_err,
  output logic              cpu_hold,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
`ifdef IMEM_ARB_STATS_EN
  ,
  output logic [15:0]       stat_if_cnt,
  output logic [15:0]       stat_ld_cnt
`endif
);

  localparam int unsigned CNT_W = $clog2(LD_MAX_WAIT + 1);

  typedef enum logic [1:0] {ST_RUN, ST_LOCKED, ST_RELEASE} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_FETCH, OWN_LOAD} owner_t;

  state_t            state, state_nxt;
  owner_t            owner, owner_nxt;
  logic [CNT_W-1:0]  wait_cnt;
  logic [ADDR_W-1:0] last_addr;
  logic [31:0]       if_rdata_q, ld_rdata_q;
  logic              ld_in_range;
  logic              ld_starved;
  logic              ld_oor_wr;

  assign ld_in_range = 32'(ld_addr) < 32'(DEPTH);
  assign ld_starved  = ld_req && (wait_cnt == CNT_W'(LD_MAX_WAIT));

  // Next state, grants and memory drive
  always_comb begin
    state_nxt = state;
    if_gnt    = 1'b0;
    ld_gnt    = 1'b0;
    case (state)
      ST_RUN: begin
        if_gnt = if_req && !ld_starved;
        ld_gnt = ld_req && !if_gnt;
        if (ld_lock) state_nxt = ST_LOCKED;
      end
      ST_LOCKED: begin
        ld_gnt = ld_req;
        if (!ld_lock) state_nxt = ST_RELEASE;
      end
      ST_RELEASE: begin
        // Hold fetch off one cycle so the last loader write lands first
        ld_gnt    = ld_req;
        state_nxt = ld_lock ? ST_LOCKED : ST_RUN;
      end
      default: state_nxt = ST_RUN;
    endcase

    mem_we    = ld_gnt && ld_we && ld_in_range;
    mem_wdata = ld_wdata;
    if (if_gnt)      mem_addr = if_addr;
    else if (ld_gnt) mem_addr = ld_addr;
    else             mem_addr = last_addr;

    ld_oor_wr = ld_gnt && ld_we && !ld_in_range;

    owner_nxt = OWN_NONE;
    if (if_gnt)               owner_nxt = OWN_FETCH;
    else if (ld_gnt && !ld_we) owner_nxt = OWN_LOAD;

    cpu_hold = (state != ST_RUN) || (if_req && !if_gnt);
  end

  // State, owner, starvation counter and return-data holding registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_RUN;
      owner      <= OWN_NONE;
      wait_cnt   <= '0;
      last_addr  <= '0;
      ld_err     <= 1'b0;
      if_rdata_q <= '0;
      ld_rdata_q <= '0;
    end else begin
      state     <= state_nxt;
      owner     <= owner_nxt;
      last_addr <= mem_addr;
      ld_err    <= ld_oor_wr;
      if (!ld_req || ld_gnt)
        wait_cnt <= '0;
      else if (wait_cnt != CNT_W'(LD_MAX_WAIT))
        wait_cnt <= wait_cnt + CNT_W'(1);
      if (owner == OWN_FETCH) if_rdata_q <= mem_rdata;
      if (owner == OWN_LOAD)  ld_rdata_q <= mem_rdata;
    end
  end

  // Read data is steered to the owner of the previous cycle's grant
  assign if_rvalid = (owner == OWN_FETCH);
  assign ld_rvalid = (owner == OWN_LOAD);
  assign if_rdata  = if_rvalid ? mem_rdata : if_rdata_q;
  assign ld_rdata  = ld_rvalid ? mem_rdata : ld_rdata_q;

`ifdef IMEM_ARB_STATS_EN
  // Saturating grant counters
  always_ff @(posedge clk) begin
    if (!reset) begin
      stat_if_cnt <= '0;
      stat_ld_cnt <= '0;
    end else begin
      if (if_gnt && stat_if_cnt != 16'hFFFF) stat_if_cnt <= stat_if_cnt + 16'd1;
      if (ld_gnt && stat_ld_cnt != 16'hFFFF) stat_ld_cnt <= stat_ld_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed self-checking bench for imem_port_arbiter with a simple
// synchronous memory model (words 0..45 preset to 32'h1000_0000 + addr).
module tb_imem_port_arbiter;

  localparam int unsigned ADDR_W = 8;

  logic              clk, reset;
  logic              if_req, if_gnt, if_rvalid;
  logic [ADDR_W-1:0] if_addr;
  logic [31:0]       if_rdata;
  logic              ld_req, ld_we, ld_lock, ld_gnt, ld_rvalid, ld_err;
  logic [ADDR_W-1:0] ld_addr;
  logic [31:0]       ld_wdata, ld_rdata;
  logic              cpu_hold, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata, mem_rdata;
`ifdef IMEM_ARB_STATS_EN
  logic [15:0]       stat_if_cnt, stat_ld_cnt;
`endif

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [256];

  imem_port_arbiter #(.ADDR_W(ADDR_W), .DEPTH(46), .LD_MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_lock(ld_lock), .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid),
    .ld_rdata(ld_rdata), .ld_err(ld_err), .cpu_hold(cpu_hold),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
`ifdef IMEM_ARB_STATS_EN
    , .stat_if_cnt(stat_if_cnt), .stat_ld_cnt(stat_ld_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = (i < 46) ? (32'h1000_0000 + 32'(i)) : 32'h0;
  end

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0; if_req = 1'b1; if_addr = 8'd0;
    ld_req = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_wdata = '0; ld_lock = 1'b0;
    tick(); tick();
    checks++; if (if_rvalid !== 1'b0) begin errors++; $display("FAIL rst_if_rvalid got=%b exp=0", if_rvalid); end
    checks++; if (ld_rvalid !== 1'b0) begin errors++; $display("FAIL rst_ld_rvalid got=%b exp=0", ld_rvalid); end
    checks++; if (ld_err !== 1'b0) begin errors++; $display("FAIL rst_ld_err got=%b exp=0", ld_err); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we got=%b exp=0", mem_we); end
    checks++; if (if_rdata !== 32'h0) begin errors++; $display("FAIL rst_if_rdata got=%h exp=0", if_rdata); end
    checks++; if (ld_rdata !== 32'h0) begin errors++; $display("FAIL rst_ld_rdata got=%h exp=0", ld_rdata); end
    reset = 1'b1; if_addr = 8'd5;
    #1;
    checks++; if (if_gnt !== 1'b1 || cpu_hold !== 1'b0 || mem_addr !== 8'd5) begin
      errors++; $display("FAIL first_fetch gnt=%b hold=%b addr=%0d exp 1/0/5", if_gnt, cpu_hold, mem_addr); end
    tick();
    if_req = 1'b0;
    checks++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h1000_0005) begin
      errors++; $display("FAIL first_rdata rvalid=%b data=%h exp 1/10000005", if_rvalid, if_rdata); end
    tick();
    checks++; if (if_rvalid !== 1'b0 || if_rdata !== 32'h1000_0005) begin
      errors++; $display("FAIL rdata_hold rvalid=%b data=%h exp 0/10000005", if_rvalid, if_rdata); end
  endtask

  task automatic test_contention;
    logic exp_ld;
    if_req = 1'b1; if_addr = 8'd3;
    ld_req = 1'b1; ld_we = 1'b0; ld_addr = 8'd7;
    for (int c = 0; c < 10; c++) begin
      exp_ld = (c == 4) || (c == 9);
      #1;
      checks++; if (if_gnt !== !exp_ld || ld_gnt !== exp_ld || cpu_hold !== exp_ld) begin
        errors++; $display("FAIL contention cyc=%0d if_gnt=%b ld_gnt=%b hold=%b exp %b/%b/%b",
                           c, if_gnt, ld_gnt, cpu_hold, !exp_ld, exp_ld, exp_ld); end
      tick();
      if (c == 4) begin
        checks++; if (ld_rvalid !== 1'b1 || if_rvalid !== 1'b0 || ld_rdata !== 32'h1000_0007) begin
          errors++; $display("FAIL contention_ld_rd ld_rvalid=%b if_rvalid=%b data=%h exp 1/0/10000007",
                             ld_rvalid, if_rvalid, ld_rdata); end
      end
      if (c == 5) begin
        checks++; if (if_rvalid !== 1'b1 || ld_rvalid !== 1'b0 || if_rdata !== 32'h1000_0003 || ld_rdata !== 32'h1000_0007) begin
          errors++; $display("FAIL contention_if_rd if_rvalid=%b ld_rvalid=%b if_data=%h ld_data=%h",
                             if_rvalid, ld_rvalid, if_rdata, ld_rdata); end
      end
    end
    if_req = 1'b0; ld_req = 1'b0;
    tick();
  endtask

  task automatic test_lock;
    if_req = 1'b1; if_addr = 8'd2; ld_lock = 1'b1; ld_req = 1'b0;
    #1;
    checks++; if (if_gnt !== 1'b1 || cpu_hold !== 1'b0) begin
      errors++; $display("FAIL lock_rise_fetch gnt=%b hold=%b exp 1/0", if_gnt, cpu_hold); end
    tick();
    ld_req = 1'b1; ld_we = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ld_addr = 8'(i); ld_wdata = 32'hA5A5_0000 + 32'(i);
      #1;
      checks++; if (if_gnt !== 1'b0 || ld_gnt !== 1'b1 || cpu_hold !== 1'b1 || mem_we !== 1'b1) begin
        errors++; $display("FAIL lock_write i=%0d if_gnt=%b ld_gnt=%b hold=%b we=%b exp 0/1/1/1",
                           i, if_gnt, ld_gnt, cpu_hold, mem_we); end
      tick();
    end
    ld_lock = 1'b0; ld_req = 1'b0; ld_we = 1'b0;
    #1;
    checks++; if (if_gnt !== 1'b0 || cpu_hold !== 1'b1) begin
      errors++; $display("FAIL lock_drop gnt=%b hold=%b exp 0/1", if_gnt, cpu_hold); end
    tick();
    checks++; if (if_gnt !== 1'b0 || cpu_hold !== 1'b1) begin
      errors++; $display("FAIL release gnt=%b hold=%b exp 0/1", if_gnt, cpu_hold); end
    tick();
    checks++; if (if_gnt !== 1'b1 || cpu_hold !== 1'b0) begin
      errors++; $display("FAIL refetch gnt=%b hold=%b exp 1/0", if_gnt, cpu_hold); end
    tick();
    if_req = 1'b0;
    checks++; if (if_rvalid !== 1'b1 || if_rdata !== 32'hA5A5_0002) begin
      errors++; $display("FAIL refetch_data rvalid=%b data=%h exp 1/a5a50002", if_rvalid, if_rdata); end
    tick();
  endtask

  task automatic test_range;
    ld_req = 1'b1; ld_we = 1'b1; ld_addr = 8'd46; ld_wdata = 32'hDEAD_BEEF;
    #1;
    checks++; if (ld_gnt !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 8'd46) begin
      errors++; $display("FAIL oor_write gnt=%b we=%b addr=%0d exp 1/0/46", ld_gnt, mem_we, mem_addr); end
    tick();
    ld_req = 1'b0;
    checks++; if (ld_err !== 1'b1 || ld_rvalid !== 1'b0) begin
      errors++; $display("FAIL oor_err err=%b rvalid=%b exp 1/0", ld_err, ld_rvalid); end
    checks++; if (mem_we !== 1'b0 || mem_addr !== 8'd46) begin
      errors++; $display("FAIL idle_hold we=%b addr=%0d exp 0/46", mem_we, mem_addr); end
    tick();
    checks++; if (ld_err !== 1'b0) begin errors++; $display("FAIL oor_err_pulse err=%b exp 0", ld_err); end
    ld_req = 1'b1; ld_addr = 8'd45; ld_wdata = 32'h0000_0045;
    #1;
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL last_write we=%b exp 1", mem_we); end
    tick();
    ld_we = 1'b0; ld_addr = 8'd50;
    checks++; if (ld_err !== 1'b0) begin errors++; $display("FAIL last_write_err err=%b exp 0", ld_err); end
    tick();
    ld_req = 1'b0;
    checks++; if (ld_rvalid !== 1'b1 || ld_rdata !== 32'h0) begin
      errors++; $display("FAIL oor_read rvalid=%b data=%h exp 1/0", ld_rvalid, ld_rdata); end
    tick();
  endtask

  task automatic test_reset_inflight;
    if_req = 1'b1; if_addr = 8'd9; ld_req = 1'b1; ld_we = 1'b0; ld_addr = 8'd1;
    tick(); tick(); tick();
    reset = 1'b0;
    #1;
    checks++; if (if_gnt !== 1'b1) begin errors++; $display("FAIL inflight_gnt gnt=%b exp 1", if_gnt); end
    tick();
    reset = 1'b1;
    checks++; if (if_rvalid !== 1'b0 || ld_rvalid !== 1'b0 || if_rdata !== 32'h0) begin
      errors++; $display("FAIL inflight_drop if_rvalid=%b ld_rvalid=%b data=%h exp 0/0/0", if_rvalid, ld_rvalid, if_rdata); end
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (ld_gnt !== (c == 4)) begin
        errors++; $display("FAIL wait_cleared cyc=%0d ld_gnt=%b exp %b", c, ld_gnt, (c == 4)); end
      tick();
    end
    if_req = 1'b0; ld_req = 1'b0;
    tick();
  endtask

`ifdef IMEM_ARB_STATS_EN
  task automatic test_stats;
    reset = 1'b0; tick(); reset = 1'b1;
    if_req = 1'b1; if_addr = 8'd1;
    for (int i = 0; i < 10; i++) tick();
    if_req = 1'b0; ld_req = 1'b1; ld_we = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    ld_req = 1'b0;
    checks++; if (stat_if_cnt !== 16'd10 || stat_ld_cnt !== 16'd3) begin
      errors++; $display("FAIL stats if=%0d ld=%0d exp 10/3", stat_if_cnt, stat_ld_cnt); end
    if_req = 1'b1;
    for (int i = 0; i < 65530; i++) tick();
    if_req = 1'b0;
    tick();
    checks++; if (stat_if_cnt !== 16'hFFFF || stat_ld_cnt !== 16'd3) begin
      errors++; $display("FAIL stats_sat if=%h ld=%0d exp ffff/3", stat_if_cnt, stat_ld_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_contention();
    test_lock();
    test_range();
    test_reset_inflight();
`ifdef IMEM_ARB_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
